// File: rtl/safe_pkg.sv
// Shared encodings for the password front-end: status codes, FSM states, keypad codes.
// Pure definitions; no logic, no latency, no flow control.
// Imported by attempt_sequencer and its helpers.
package safe_pkg;

    localparam logic [1:0] ST_LOCKED  = 2'b00;
    localparam logic [1:0] ST_OPEN    = 2'b01;
    localparam logic [1:0] ST_LOCKOUT = 2'b10;
    localparam logic [1:0] ST_ALARM   = 2'b11;

    localparam logic [2:0] S_LOCKED  = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
    localparam logic [2:0] S_ALARM   = 3'd4;

    localparam logic [3:0] KEY_CLEAR = 4'hC;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell periods.
// Load takes effect next cycle; done is combinational on the last counted cycle.
// No backpressure: en simply pauses the count, value holds at 0.
module cycle_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] value,
    output logic          done
);

    // done marks the edge on which value goes 1 -> 0, so the owner can switch state in step.
    assign done = en && !load && (value == TW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (value != '0)) begin
            value <= value - TW'(1);
        end
    end

endmodule

// File: rtl/attempt_sequencer.sv
// Keypad entry collector, checker req/ack framing, failure count, lockout and auto-relock.
// Confirm -> Chk_req after 1 cycle; checker verdict reflected in status 1 cycle after Chk_ack.
// Chk_req holds until acked; En=0 freezes everything but still completes a pending handshake.
// Optional ALARM_LOCKOUT_EN: a repeat lockout with no pass in between latches ALARM until Res.
module attempt_sequencer
    import safe_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int MAX_ERR     = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int OPEN_CYC    = 5000,
    parameter int TW          = 16
) (
    input  logic                  Clk,
    input  logic                  Res,
    input  logic                  En,
    input  logic                  Key_valid,
    input  logic [3:0]            Key_code,
    input  logic                  Confirm,
    input  logic                  Lock,
    output logic                  Chk_req,
    output logic [4*DIGITS-1:0]   Chk_code,
    input  logic                  Chk_ack,
    input  logic                  Chk_pass,
    output logic [1:0]            status,
    output logic [1:0]            ECounter,
    output logic [TW-1:0]         Time_left
);

    localparam int CW = $clog2(DIGITS + 1);

    logic [2:0]          state;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] entry_q;
    logic [1:0]          ecnt;
    logic                chk_req;
    logic                pend_vld;
    logic                pend_pass;

    logic          entry_full;
    logic          ack_now;
    logic          res_vld;
    logic          res_pass;
    logic          pass_evt;
    logic          fail_evt;
    logic [1:0]    ecnt_inc;
    logic          lock_hit;
    logic          go_alarm;
    logic          tmr_en;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    assign entry_full = (cnt == CW'(DIGITS));
    assign ack_now    = chk_req && Chk_ack;
    // An ack taken while frozen is parked in pend_* and applied once En returns.
    assign res_vld    = ack_now || pend_vld;
    assign res_pass   = ack_now ? Chk_pass : pend_pass;
    assign pass_evt   = En && (state == S_CHECK) && res_vld && res_pass;
    assign fail_evt   = En && (((state == S_LOCKED) && Confirm && !entry_full) ||
                               ((state == S_CHECK) && res_vld && !res_pass));
    assign ecnt_inc   = ecnt + 2'd1;
    assign lock_hit   = (ecnt_inc == 2'(MAX_ERR));
    assign tmr_en     = En && ((state == S_OPEN) || (state == S_LOCKOUT));

`ifdef ALARM_LOCKOUT_EN
    logic armed;
    assign go_alarm = armed;

    always_ff @(posedge Clk) begin
        if (Res) begin
            armed <= 1'b0;
        end else if (pass_evt) begin
            armed <= 1'b0;
        end else if (fail_evt && lock_hit) begin
            armed <= 1'b1;
        end
    end
`else
    assign go_alarm = 1'b0;
`endif

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (pass_evt) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(OPEN_CYC);
        end else if (fail_evt && lock_hit && !go_alarm) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(LOCKOUT_CYC);
        end else if (En && (state == S_OPEN) && Lock) begin
            tmr_load = 1'b1;
        end
    end

    cycle_timer #(.TW(TW)) u_timer (
        .clk      (Clk),
        .rst      (Res),
        .en       (tmr_en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (Time_left),
        .done     (tmr_done)
    );

    always_ff @(posedge Clk) begin
        if (Res) begin
            state     <= S_LOCKED;
            cnt       <= '0;
            entry_q   <= '0;
            ecnt      <= '0;
            chk_req   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_pass <= 1'b0;
        end else begin
            if (ack_now) begin
                chk_req <= 1'b0;
                if (!En) begin
                    pend_vld  <= 1'b1;
                    pend_pass <= Chk_pass;
                end
            end
            if (En) begin
                case (state)
                    S_LOCKED: begin
                        if (Confirm) begin
                            if (entry_full) begin
                                chk_req <= 1'b1;
                                state   <= S_CHECK;
                            end else begin
                                cnt     <= '0;
                                entry_q <= '0;
                            end
                        end else if (Key_valid) begin
                            if (Key_code == KEY_CLEAR) begin
                                cnt     <= '0;
                                entry_q <= '0;
                            end else if (is_digit(Key_code) && !entry_full) begin
                                entry_q[4*cnt +: 4] <= Key_code;
                                cnt                 <= cnt + CW'(1);
                            end
                        end
                    end
                    S_CHECK: begin
                        if (res_vld) begin
                            pend_vld <= 1'b0;
                            cnt      <= '0;
                            entry_q  <= '0;
                            if (res_pass) begin
                                ecnt  <= '0;
                                state <= S_OPEN;
                            end
                        end
                    end
                    S_OPEN: begin
                        if (Lock || tmr_done) state <= S_LOCKED;
                    end
                    S_LOCKOUT: begin
                        if (tmr_done) begin
                            state <= S_LOCKED;
                            ecnt  <= '0;
                        end
                    end
                    default: ;
                endcase
                // Failure bookkeeping overrides the per-state next state above.
                if (fail_evt) begin
                    ecnt <= ecnt_inc;
                    if (lock_hit) state <= go_alarm ? S_ALARM : S_LOCKOUT;
                    else          state <= S_LOCKED;
                end
            end
        end
    end

    always_comb begin
        case (state)
            S_OPEN:    status = ST_OPEN;
            S_LOCKOUT: status = ST_LOCKOUT;
            S_ALARM:   status = ST_ALARM;
            default:   status = ST_LOCKED;
        endcase
    end

    assign Chk_req  = chk_req;
    assign Chk_code = entry_q;
    assign ECounter = ecnt;

endmodule

// File: tb/tb_attempt_sequencer.sv
// Directed bench for attempt_sequencer with default parameters.
module tb_attempt_sequencer;

    logic        Clk = 1'b0;
    logic        Res;
    logic        En;
    logic        Key_valid;
    logic [3:0]  Key_code;
    logic        Confirm;
    logic        Lock;
    logic        Chk_req;
    logic [23:0] Chk_code;
    logic        Chk_ack;
    logic        Chk_pass;
    logic [1:0]  status;
    logic [1:0]  ECounter;
    logic [15:0] Time_left;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    attempt_sequencer dut (
        .Clk       (Clk),
        .Res       (Res),
        .En        (En),
        .Key_valid (Key_valid),
        .Key_code  (Key_code),
        .Confirm   (Confirm),
        .Lock      (Lock),
        .Chk_req   (Chk_req),
        .Chk_code  (Chk_code),
        .Chk_ack   (Chk_ack),
        .Chk_pass  (Chk_pass),
        .status    (status),
        .ECounter  (ECounter),
        .Time_left (Time_left)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] k);
        Key_valid = 1'b1;
        Key_code  = k;
        tick();
        Key_valid = 1'b0;
    endtask

    task automatic confirm();
        Confirm = 1'b1;
        tick();
        Confirm = 1'b0;
    endtask

    task automatic ack(input logic pass);
        Chk_ack  = 1'b1;
        Chk_pass = pass;
        tick();
        Chk_ack  = 1'b0;
        Chk_pass = 1'b0;
    endtask

    task automatic six(input logic [3:0] d);
        for (int i = 0; i < 6; i++) key(d);
    endtask

    initial begin
        Res = 1'b1; En = 1'b1; Key_valid = 1'b0; Key_code = 4'h0;
        Confirm = 1'b0; Lock = 1'b0; Chk_ack = 1'b0; Chk_pass = 1'b0;
        tick(2);
        Res = 1'b0;
        chk("rst_status", status, 2'b00);
        chk("rst_ecnt", ECounter, 2'd0);
        chk("rst_req", Chk_req, 1'b0);
        chk("rst_code", Chk_code, 24'h0);
        chk("rst_time", Time_left, 16'd0);

        // Pass path: 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) key(i[0] ? 4'd1 : 4'd0);
        chk("pre_confirm_req", Chk_req, 1'b0);
        confirm();
        chk("pass_req_lat1", Chk_req, 1'b1);
        chk("pass_code", Chk_code, 24'h101010);
        chk("check_status", status, 2'b00);
        key(4'd7);
        chk("check_key_ignored", Chk_code, 24'h101010);
        tick();
        chk("req_held", Chk_req, 1'b1);
        ack(1'b1);
        chk("pass_req_drop", Chk_req, 1'b0);
        chk("pass_status", status, 2'b01);
        chk("pass_ecnt", ECounter, 2'd0);
        chk("pass_time", Time_left, 16'd5000);
        chk("pass_code_clr", Chk_code, 24'h0);
        tick();
        chk("open_dec", Time_left, 16'd4999);
        Lock = 1'b1; tick(); Lock = 1'b0;
        chk("lock_status", status, 2'b00);
        chk("lock_time", Time_left, 16'd0);

        // Short entry counts as an immediate failure
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        confirm();
        chk("short_req", Chk_req, 1'b0);
        chk("short_ecnt", ECounter, 2'd1);
        chk("short_status", status, 2'b00);

        // Seventh digit dropped
        for (int i = 1; i <= 7; i++) key(4'(i));
        confirm();
        chk("ovf_code", Chk_code, 24'h654321);
        ack(1'b0);
        chk("fail2_ecnt", ECounter, 2'd2);
        chk("fail2_status", status, 2'b00);

        // Clear key, then key+Confirm in the same cycle
        key(4'd9); key(4'd9); key(4'd9); key(4'hC);
        six(4'd2);
        Key_valid = 1'b1; Key_code = 4'd7; Confirm = 1'b1;
        tick();
        Key_valid = 1'b0; Confirm = 1'b0;
        chk("clr_req", Chk_req, 1'b1);
        chk("clr_code", Chk_code, 24'h222222);
        ack(1'b0);
        chk("lockout_status", status, 2'b10);
        chk("lockout_ecnt", ECounter, 2'd3);
        chk("lockout_time", Time_left, 16'd1000);
        tick(10);
        Confirm = 1'b1; tick(); Confirm = 1'b0;
        chk("lockout_confirm_ign", Chk_req, 1'b0);
        chk("lockout_time_dec", Time_left, 16'd989);
        tick(988);
        chk("lockout_last", Time_left, 16'd1);
        chk("lockout_last_status", status, 2'b10);
        tick();
        chk("lockout_exit_status", status, 2'b00);
        chk("lockout_exit_ecnt", ECounter, 2'd0);
        chk("lockout_exit_time", Time_left, 16'd0);

        // Ack accepted while frozen, applied after En returns
        six(4'd5);
        confirm();
        En = 1'b0;
        ack(1'b1);
        chk("frz_req_drop", Chk_req, 1'b0);
        chk("frz_status", status, 2'b00);
        tick(2);
        chk("frz_status_hold", status, 2'b00);
        En = 1'b1;
        tick();
        chk("frz_applied", status, 2'b01);
        chk("frz_time", Time_left, 16'd5000);
        En = 1'b0;
        tick(3);
        chk("frz_timer_held", Time_left, 16'd5000);
        En = 1'b1;
        tick();
        chk("open_dec2", Time_left, 16'd4999);
        tick(4998);
        chk("open_last", Time_left, 16'd1);
        chk("open_last_status", status, 2'b01);
        tick();
        chk("relock_status", status, 2'b00);
        chk("relock_time", Time_left, 16'd0);

        // Reset mid-CHECK, stray ack afterwards
        six(4'd3);
        confirm();
        chk("rc_req", Chk_req, 1'b1);
        Res = 1'b1; tick(); Res = 1'b0;
        chk("rc_req_drop", Chk_req, 1'b0);
        ack(1'b1);
        chk("stray_status", status, 2'b00);
        chk("stray_req", Chk_req, 1'b0);

        // Two lockouts with no pass in between
        Confirm = 1'b1;
        tick(); chk("rep_e1", ECounter, 2'd1);
        tick(); chk("rep_e2", ECounter, 2'd2);
        tick();
        Confirm = 1'b0;
        chk("rep_lockout1", status, 2'b10);
        tick(1000);
        chk("rep_unlock", status, 2'b00);
        Confirm = 1'b1; tick(3); Confirm = 1'b0;
`ifdef ALARM_LOCKOUT_EN
        chk("rep_alarm", status, 2'b11);
        chk("rep_alarm_time", Time_left, 16'd0);
        tick(1200);
        chk("alarm_sticky", status, 2'b11);
        Res = 1'b1; tick(); Res = 1'b0;
        chk("alarm_res", status, 2'b00);
`else
        chk("rep_lockout2", status, 2'b10);
        chk("rep_lockout2_time", Time_left, 16'd1000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
